// File: rtl/zap_fetch_sequencer.sv
// ZAP fetch sequencer: generates the fetch PC, issues single-outstanding
// I-cache reads, discards stale responses after a redirect, and buffers up
// to two returned instructions for the fetch stage.
module zap_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic [31:0] i_pc_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    output logic        o_icache_req,
    output logic [31:0] o_icache_addr,
    input  logic        i_icache_stall,
    input  logic        i_icache_valid,
    input  logic [31:0] i_icache_instr,
    input  logic        i_icache_abort,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc
);

    // S_DRAIN: a redirect left a request in flight; its response is discarded.
    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HALT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [1:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic [31:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
    logic        head_abort_q, head_abort_d;
    logic [31:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;
    logic        tail_abort_q, tail_abort_d;

    logic        wb_clr_s, alu_clr_s, clr_s, stall_s;
    logic        outstanding_s, accept_s, push_s, pop_s;
    logic [31:0] target_s, new_instr_s, new_pc_s;

    // Resolve clear/stall priority and the per-cycle handshake events.
    always_comb begin
        wb_clr_s      = i_clear_from_writeback;
        alu_clr_s     = i_clear_from_alu & ~wb_clr_s & ~i_data_stall;
        clr_s         = wb_clr_s | alu_clr_s;
        stall_s       = ~clr_s & (i_data_stall | i_stall_from_issue | i_stall_from_decode);
        outstanding_s = (state_q == S_WAIT) | (state_q == S_DRAIN);
        accept_s      = req_q & ~i_icache_stall & ~clr_s;
        push_s        = (state_q == S_WAIT) & i_icache_valid & ~clr_s;
        pop_s         = (count_q != 2'd0) & ~clr_s & ~stall_s;
        if (wb_clr_s) begin
            target_s = i_pc_from_writeback & 32'hFFFF_FFFC;
        end else begin
            target_s = i_pc_from_alu & 32'hFFFF_FFFC;
        end
        // The fetch address already advanced on accept, so the in-flight PC is addr - 4.
        new_pc_s = addr_q - 32'd4;
        if (i_icache_abort) begin
            new_instr_s = 32'h0000_0000;
        end else begin
            new_instr_s = i_icache_instr;
        end
    end

    // Two-entry buffer next state: flush on clear, otherwise pop then push.
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_abort_d = head_abort_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_abort_d = tail_abort_q;
        tail_pc_d    = tail_pc_q;
        if (clr_s) begin
            count_d = 2'd0;
        end else begin
            case ({pop_s, push_s})
                2'b01: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = new_instr_s;
                        head_abort_d = i_icache_abort;
                        head_pc_d    = new_pc_s;
                        count_d      = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_instr_d = new_instr_s;
                        tail_abort_d = i_icache_abort;
                        tail_pc_d    = new_pc_s;
                        count_d      = 2'd2;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b10: begin
                    head_instr_d = tail_instr_q;
                    head_abort_d = tail_abort_q;
                    head_pc_d    = tail_pc_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_instr_d = new_instr_s;
                        head_abort_d = i_icache_abort;
                        head_pc_d    = new_pc_s;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_abort_d = tail_abort_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = new_instr_s;
                        tail_abort_d = i_icache_abort;
                        tail_pc_d    = new_pc_s;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    // Fetch state, PC and request next state; a request needs a free buffer slot.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (clr_s) begin
            addr_d = target_s;
            if (outstanding_s & ~i_icache_valid) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_ISSUE;
            end
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (accept_s) begin
                        state_d = S_WAIT;
                        addr_d  = addr_q + 32'd4;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (i_icache_valid & i_icache_abort) begin
                        state_d = S_HALT;
                    end else if (i_icache_valid) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                S_DRAIN: begin
                    if (i_icache_valid) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_ISSUE;
                end
            endcase
        end
        req_d = (state_d == S_ISSUE) & (count_d != 2'd2);
    end

    // Register all sequencer state; synchronous reset restores the reset vector.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_ISSUE;
            addr_q       <= RESET_VECTOR;
            req_q        <= 1'b0;
            count_q      <= 2'd0;
            valid_q      <= 1'b0;
            head_instr_q <= 32'h0000_0000;
            head_abort_q <= 1'b0;
            head_pc_q    <= RESET_VECTOR;
            tail_instr_q <= 32'h0000_0000;
            tail_abort_q <= 1'b0;
            tail_pc_q    <= RESET_VECTOR;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            head_instr_q <= head_instr_d;
            head_abort_q <= head_abort_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_abort_q <= tail_abort_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign o_icache_req  = req_q;
    assign o_icache_addr = addr_q;
    assign o_valid       = valid_q;
    assign o_instruction = head_instr_q;
    assign o_instr_abort = head_abort_q;
    assign o_pc          = head_pc_q;

endmodule

// File: tb/tb_zap_fetch_sequencer.sv
// Self-checking bench for zap_fetch_sequencer: an I-cache model with random
// latency feeds the DUT; a transaction-level model (expected fetch PC plus a
// queue of instructions owed to the fetch stage) checks every cycle.
module tb_zap_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear_from_writeback = 1'b0;
    logic [31:0] i_pc_from_writeback = 32'h0;
    logic        i_data_stall = 1'b0;
    logic        i_clear_from_alu = 1'b0;
    logic [31:0] i_pc_from_alu = 32'h0;
    logic        i_stall_from_issue = 1'b0;
    logic        i_stall_from_decode = 1'b0;
    logic        o_icache_req;
    logic [31:0] o_icache_addr;
    logic        i_icache_stall = 1'b0;
    logic        i_icache_valid = 1'b0;
    logic [31:0] i_icache_instr = 32'h0;
    logic        i_icache_abort = 1'b0;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_instr_abort;
    logic [31:0] o_pc;

    zap_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_pc_from_writeback(i_pc_from_writeback),
        .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_pc_from_alu(i_pc_from_alu),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .o_icache_req(o_icache_req), .o_icache_addr(o_icache_addr),
        .i_icache_stall(i_icache_stall), .i_icache_valid(i_icache_valid),
        .i_icache_instr(i_icache_instr), .i_icache_abort(i_icache_abort),
        .o_instruction(o_instruction), .o_valid(o_valid),
        .o_instr_abort(o_instr_abort), .o_pc(o_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        abort;
    } ent_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    ent_t        exp_q[$];
    logic [31:0] exp_pc = RV;
    int          epoch = 0;
    bit          halted = 1'b0;
    int          pops = 0;
    bit          last_accept = 1'b0;
    bit          pend_v = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_epoch = 0;
    int          pend_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rand_icstall = 1'b0;
    bit          force_icstall = 1'b0;
    bit          rand_abort = 1'b0;
    logic [31:0] abort_addr = 32'h0000_0001;

    function automatic logic [31:0] mem_instr(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic bit is_abort(input logic [31:0] a);
        return (a == abort_addr) || (rand_abort && (a[5:2] == 4'hF));
    endfunction

    // One clock: drive the cache, check the DUT against the model, advance.
    task automatic cycle();
        bit   deliver, was_pend, wbc, aluc, clr, stl, acc, pop;
        ent_t e;
        deliver  = pend_v && (pend_cnt == 0);
        was_pend = pend_v && !deliver;
        i_icache_valid = deliver;
        i_icache_abort = deliver ? is_abort(pend_addr) : 1'($urandom_range(0, 1));
        i_icache_instr = $urandom;
        if (deliver && !is_abort(pend_addr)) i_icache_instr = mem_instr(pend_addr);
        i_icache_stall = pend_v || force_icstall || (rand_icstall && ($urandom_range(0, 3) == 0));
        wbc  = i_clear_from_writeback;
        aluc = i_clear_from_alu && !wbc && !i_data_stall;
        clr  = wbc || aluc;
        stl  = !clr && (i_data_stall || i_stall_from_issue || i_stall_from_decode);
        last_accept = 1'b0;
        if (i_reset) begin
            exp_q.delete();
            epoch++;
            exp_pc = RV;
            halted = 1'b0;
        end else begin
            vec_cnt++;
            if (o_valid !== (exp_q.size() != 0))
                begin err_cnt++; $display("FAIL o_valid: got %b expected %b at %0t", o_valid, exp_q.size() != 0, $time); end
            if (exp_q.size() != 0) begin
                vec_cnt++;
                if ({o_pc, o_instruction, o_instr_abort} !== {exp_q[0].pc, exp_q[0].instr, exp_q[0].abort}) begin
                    err_cnt++;
                    $display("FAIL head: got pc=%h instr=%h abort=%b expected pc=%h instr=%h abort=%b at %0t",
                             o_pc, o_instruction, o_instr_abort, exp_q[0].pc, exp_q[0].instr, exp_q[0].abort, $time);
                end
            end
            if (halted) begin
                vec_cnt++;
                if (o_icache_req !== 1'b0)
                    begin err_cnt++; $display("FAIL halt_req: got %b expected 0 at %0t", o_icache_req, $time); end
            end
            acc = (o_icache_req === 1'b1) && !i_icache_stall && !clr;
            if (acc) begin
                vec_cnt++;
                if (o_icache_addr !== exp_pc)
                    begin err_cnt++; $display("FAIL fetch_addr: got %h expected %h at %0t", o_icache_addr, exp_pc, $time); end
                pend_v      = 1'b1;
                pend_addr   = exp_pc;
                pend_epoch  = epoch;
                pend_cnt    = int'($urandom_range(lat_min, lat_max)) - 1;
                exp_pc      = exp_pc + 32'd4;
                last_accept = 1'b1;
            end
            pop = (exp_q.size() != 0) && !clr && !stl;
            if (pop) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (deliver && !clr && (pend_epoch == epoch)) begin
                e.pc    = pend_addr;
                e.abort = is_abort(pend_addr);
                e.instr = e.abort ? 32'h0 : mem_instr(pend_addr);
                exp_q.push_back(e);
                if (e.abort) halted = 1'b1;
                vec_cnt++;
                if (exp_q.size() > 2)
                    begin err_cnt++; $display("FAIL overflow: got %0d entries expected at most 2", exp_q.size()); end
            end
            if (clr) begin
                exp_q.delete();
                epoch++;
                exp_pc = (wbc ? i_pc_from_writeback : i_pc_from_alu) & 32'hFFFF_FFFC;
                halted = 1'b0;
            end
        end
        if (deliver) pend_v = 1'b0;
        if (was_pend) pend_cnt--;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_icache_req === 1'b1) begin ok = 1'b1; break; end
            cycle();
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_accept) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid === 1'b1) begin ok = 1'b1; break; end
            cycle();
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) cycle();
        vec_cnt++; if (o_icache_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %b expected 0", o_icache_req); end
        vec_cnt++; if (o_icache_addr !== RV) begin err_cnt++; $display("FAIL rst_addr: got %h expected %h", o_icache_addr, RV); end
        vec_cnt++; if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        vec_cnt++; if (o_instr_abort !== 1'b0) begin err_cnt++; $display("FAIL rst_abort: got %b expected 0", o_instr_abort); end
        vec_cnt++; if (o_instruction !== 32'h0) begin err_cnt++; $display("FAIL rst_instr: got %h expected 0", o_instruction); end
        vec_cnt++; if (o_pc !== RV) begin err_cnt++; $display("FAIL rst_pc: got %h expected %h", o_pc, RV); end
        i_reset = 1'b0;
    endtask

    task automatic test_stream();
        int p0;
        lat_min = 1; lat_max = 1;
        cycle();
        vec_cnt++;
        if ({o_icache_req, o_icache_addr} !== {1'b1, RV})
            begin err_cnt++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", o_icache_req, o_icache_addr, RV); end
        p0 = pops;
        repeat (14) cycle();
        vec_cnt++;
        if (pops - p0 < 4) begin err_cnt++; $display("FAIL stream_progress: got %0d pops expected >= 4", pops - p0); end
    endtask

    task automatic test_stall_decode();
        i_stall_from_decode = 1'b1;
        repeat (6) cycle();
        vec_cnt++; if (o_icache_req !== 1'b0) begin err_cnt++; $display("FAIL full_req: got %b expected 0", o_icache_req); end
        vec_cnt++; if (o_valid !== 1'b1) begin err_cnt++; $display("FAIL full_valid: got %b expected 1", o_valid); end
        i_stall_from_decode = 1'b0;
        repeat (10) cycle();
    endtask

    task automatic test_alu_redirect();
        bit ok;
        lat_min = 3; lat_max = 3;
        i_clear_from_writeback = 1'b1; i_pc_from_writeback = 32'h0000_0200;
        cycle();
        i_clear_from_writeback = 1'b0;
        wait_accept(ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL accept_200: got timeout expected accept"); end
        i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h0000_1002;
        cycle();
        i_clear_from_alu = 1'b0;
        vec_cnt++;
        if ({o_icache_req, o_valid} !== 2'b00)
            begin err_cnt++; $display("FAIL drain: got req=%b valid=%b expected 0 0", o_icache_req, o_valid); end
        wait_valid(ok);
        vec_cnt++;
        if (!ok || o_pc !== 32'h0000_1000 || o_instruction !== mem_instr(32'h0000_1000))
            begin err_cnt++; $display("FAIL redirect_first: got pc=%h instr=%h expected pc=00001000 instr=%h", o_pc, o_instruction, mem_instr(32'h0000_1000)); end
    endtask

    task automatic test_dual_clear();
        bit ok;
        logic [31:0] a;
        lat_min = 1; lat_max = 1;
        wait_req(ok);
        i_clear_from_writeback = 1'b1; i_pc_from_writeback = 32'h0000_0040;
        i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h0000_0080;
        cycle();
        i_clear_from_writeback = 1'b0; i_clear_from_alu = 1'b0;
        vec_cnt++;
        if ({o_icache_req, o_icache_addr} !== {1'b1, 32'h0000_0040})
            begin err_cnt++; $display("FAIL wb_wins: got req=%b addr=%h expected req=1 addr=00000040", o_icache_req, o_icache_addr); end
        repeat (3) cycle();
        wait_req(ok);
        a = o_icache_addr;
        force_icstall = 1'b1; i_data_stall = 1'b1;
        i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h0000_0080;
        cycle();
        force_icstall = 1'b0; i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
        vec_cnt++;
        if (!ok || {o_icache_req, o_icache_addr} !== {1'b1, a})
            begin err_cnt++; $display("FAIL masked_alu: got req=%b addr=%h expected req=1 addr=%h", o_icache_req, o_icache_addr, a); end
        repeat (6) cycle();
    endtask

    task automatic test_abort();
        bit ok;
        abort_addr = 32'h0000_0300;
        wait_req(ok);
        i_clear_from_writeback = 1'b1; i_pc_from_writeback = 32'h0000_0300;
        cycle();
        i_clear_from_writeback = 1'b0;
        wait_valid(ok);
        vec_cnt++;
        if (!ok || {o_pc, o_instruction, o_instr_abort} !== {32'h0000_0300, 32'h0, 1'b1})
            begin err_cnt++; $display("FAIL abort_entry: got pc=%h instr=%h abort=%b expected 00000300 00000000 1", o_pc, o_instruction, o_instr_abort); end
        repeat (8) cycle();
        vec_cnt++; if (o_icache_req !== 1'b0) begin err_cnt++; $display("FAIL halted: got req=%b expected 0", o_icache_req); end
        i_clear_from_writeback = 1'b1; i_pc_from_writeback = 32'h0000_0010;
        cycle();
        i_clear_from_writeback = 1'b0;
        vec_cnt++;
        if ({o_icache_req, o_icache_addr} !== {1'b1, 32'h0000_0010})
            begin err_cnt++; $display("FAIL unhalt: got req=%b addr=%h expected req=1 addr=00000010", o_icache_req, o_icache_addr); end
        abort_addr = 32'h0000_0001;
        repeat (4) cycle();
    endtask

    task automatic test_wrap();
        bit ok;
        wait_req(ok);
        i_clear_from_alu = 1'b1; i_pc_from_alu = 32'hFFFF_FFFC;
        cycle();
        i_clear_from_alu = 1'b0;
        wait_accept(ok);
        wait_req(ok);
        vec_cnt++;
        if (!ok || o_icache_addr !== 32'h0000_0000)
            begin err_cnt++; $display("FAIL wrap: got addr=%h expected 00000000", o_icache_addr); end
        repeat (4) cycle();
    endtask

    task automatic test_reset_outstanding();
        bit ok;
        lat_min = 3; lat_max = 3;
        wait_accept(ok);
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        repeat (3) cycle();
        vec_cnt++;
        if (!ok || o_valid !== 1'b0) begin err_cnt++; $display("FAIL stale_after_reset: got valid=%b expected 0", o_valid); end
        repeat (10) cycle();
    endtask

    task automatic test_random();
        int p0;
        p0 = pops;
        lat_min = 1; lat_max = 4; rand_icstall = 1'b1; rand_abort = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            i_clear_from_writeback = ($urandom_range(0, 19) == 0);
            i_clear_from_alu       = ($urandom_range(0, 11) == 0);
            i_data_stall           = ($urandom_range(0, 5) == 0);
            i_stall_from_issue     = ($urandom_range(0, 7) == 0);
            i_stall_from_decode    = ($urandom_range(0, 4) == 0);
            i_pc_from_writeback    = 32'h0000_2000 + 32'($urandom_range(0, 255));
            i_pc_from_alu          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                                 : 32'h0000_3000 + 32'($urandom_range(0, 255));
            cycle();
        end
        i_clear_from_writeback = 1'b0; i_clear_from_alu = 1'b0; i_data_stall = 1'b0;
        i_stall_from_issue = 1'b0; i_stall_from_decode = 1'b0; rand_icstall = 1'b0;
        repeat (10) cycle();
        vec_cnt++;
        if (pops - p0 < 50) begin err_cnt++; $display("FAIL random_progress: got %0d pops expected >= 50", pops - p0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_decode();
        test_alu_redirect();
        test_dual_clear();
        test_abort();
        test_wrap();
        test_reset_outstanding();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zap_fetch_sequencer.md
# zap_fetch_sequencer

Sequences instruction fetch for the ZAP front end. Generates the fetch PC, issues single-outstanding read requests to the I-cache, and discards responses made stale by a redirect. Holds returned instructions in a 2-entry buffer so pipeline stalls never drop an instruction, and presents them to the fetch stage in its valid/instruction/abort format. Sits between the I-cache and the fetch stage and applies the same clear/stall priority order as that stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- i_clk  in  1  ZAP clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clear_from_writeback  in  1  redirect, highest priority.
- i_pc_from_writeback  in  32  target PC for the writeback redirect.
- i_data_stall  in  1  freeze; masks the ALU clear.
- i_clear_from_alu  in  1  redirect (branch).
- i_pc_from_alu  in  32  target PC for the ALU redirect.
- i_stall_from_issue  in  1  freeze.
- i_stall_from_decode  in  1  freeze, lowest priority.
- o_icache_req  out  1  fetch request.
- o_icache_addr  out  32  fetch address, word aligned.
- i_icache_stall  in  1  cache cannot accept the request this cycle.
- i_icache_valid  in  1  response valid.
- i_icache_instr  in  32  response instruction.
- i_icache_abort  in  1  response is an instruction abort.
- o_instruction  out  32  buffer-head instruction, to the fetch stage.
- o_valid  out  1  buffer head is valid.
- o_instr_abort  out  1  buffer head is an abort.
- o_pc  out  32  PC of the buffer head.

## Operation
- Effective events each cycle:
  - wb_clr = i_clear_from_writeback.
  - alu_clr = i_clear_from_alu & !wb_clr & !i_data_stall.
  - clr = wb_clr | alu_clr.
  - stall = !clr & (i_data_stall | i_stall_from_issue | i_stall_from_decode).
- Pop: buffer non-empty & !clr & !stall. The fetch stage samples the head on this edge.
- Accept: o_icache_req & !i_icache_stall & !clr. On accept, o_icache_addr += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and the state moves to S_WAIT.
- States:
  - S_ISSUE: request when occupancy (buffer count) < 2 and no abort is pending.
  - S_WAIT: one request outstanding, o_icache_req = 0. On i_icache_valid, push {instr, abort, pc}, then go to S_ISSUE, or to S_HALT if abort = 1.
  - S_HALT: no requests until clr.
- The request is issued only when buffer count + outstanding ≤ 1 after this cycle's pop, so the buffer never overflows.
- Push and pop in the same cycle are allowed; the count is unchanged.
- An abort entry carries instruction 0x0000_0000 and abort = 1, and o_valid = 1.
- On clr:
  - Flush the buffer.
  - o_icache_addr <= target PC with bits [1:0] forced to 0. wb_clr uses i_pc_from_writeback; alu_clr uses i_pc_from_alu.
  - State goes to S_ISSUE from any state.
  - If in S_WAIT with no response this cycle, set a drop flag and wait in S_DRAIN. The next i_icache_valid is discarded, then the state moves to S_ISSUE.
  - A response arriving in the same cycle as clr is discarded.
- Writeback clear wins over a simultaneous ALU clear. i_data_stall suppresses the ALU clear (ALU target ignored) but never the writeback clear.
- Stalls alone never flush. Requests and responses continue under a stall until the buffer is full.

## Timing
- Reset values:
  - o_icache_req = 0, o_icache_addr = RESET_VECTOR.
  - o_valid = 0, o_instr_abort = 0, o_instruction = 0, o_pc = RESET_VECTOR.
  - Buffer empty, drop flag 0, state S_ISSUE.
- o_icache_req is registered. It asserts on the first cycle after reset deasserts.
- The request is held stable while i_icache_stall = 1.
- Response to output: i_icache_valid at cycle N appears on o_valid / o_instruction at cycle N+1. The head and count are registered; outputs are driven from the head register.
- Redirect: clr at cycle N gives o_icache_req = 1 with the new address at cycle N+1, or once the drop completes. o_valid = 0 from cycle N+1.
- Reset during an outstanding request returns all state to reset values. The response to the pre-reset request arrives while S_ISSUE is active and must be ignored: responses are only accepted in S_WAIT/S_DRAIN.

## Test plan
- Reset, RESET_VECTOR = 0x100, 1-cycle cache -> requests at 0x100, 0x104, 0x108. o_valid shows those instructions with o_pc 0x100, 0x104.
- i_stall_from_decode held 6 cycles -> buffer fills to 2, o_icache_req drops, no instruction lost. After release, the outputs are the consecutive PCs with no gap or duplicate.
- Outstanding request to 0x200, i_clear_from_alu with target 0x1002 -> that response is dropped. The next request is at 0x1000, and the first o_valid instruction comes from 0x1000.
- i_clear_from_writeback (0x40) and i_clear_from_alu (0x80) in the same cycle -> next request at 0x40. Repeat the ALU clear alone with i_data_stall = 1 -> the clear is ignored and the PC continues.
- Abort response for 0x300 -> one entry with o_instruction 0, o_instr_abort 1, o_valid 1. No further requests until i_clear_from_writeback to 0x10, after which the request is at 0x10.
- PC at 0xFFFF_FFFC accepted -> next o_icache_addr is 0x0000_0000.
